// File: rtl/point_renderer.sv
// point_renderer: streams NUM_POINTS packed point records from ZBT, shifts x, clips, emits {x,y,pixel}.
// Latency: first point READ_LATENCY+1 cycles after entering FETCH, then one point per cycle.
// Backpressure: reads issue only while fifo_count+inflight < FIFO_DEPTH; outputs hold while !out_ready.
// Build option: define POINT_RENDERER_DEPTH_INVERT_EN to emit pixel = ~z[9:2] (near points bright).
module point_renderer #(
  parameter int ADDR_WIDTH   = 19,
  parameter int BASE_ADDR    = 0,
  parameter int NUM_POINTS   = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int OFFSET_WIDTH = 6,
  parameter int SCREEN_W     = 1024,
  parameter int SCREEN_H     = 768
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [OFFSET_WIDTH-1:0] camera_offset,
  input  logic [35:0]             zbt_read_data,
  output logic [ADDR_WIDTH-1:0]   zbt_read_addr,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [10:0]             x,
  output logic [9:0]              y,
  output logic [7:0]              pixel,
  output logic                    busy,
  output logic                    frame_done,
  output logic [ADDR_WIDTH-1:0]   clip_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_POINTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  pixel;
  } pt_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                  r_state;
  logic [OFFSET_WIDTH-1:0] r_offset;
  logic [IDX_W-1:0]        r_index;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_busy;
  logic                    r_frame_done;
  logic [ADDR_WIDTH-1:0]   r_clip_count;
  logic [READ_LATENCY-1:0] r_tag;
  pt_t                     r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  logic [CNT_W-1:0] w_inflight;
  logic             w_issue;
  logic             w_ret;
  logic [9:0]       w_rec_x;
  logic [9:0]       w_rec_y;
  logic [10:0]      w_xs;
  logic [7:0]       w_pixel;
  logic             w_clip;
  logic             w_push;
  logic             w_pop;
  pt_t              w_entry;
  pt_t              w_head;
  logic             w_unused_bits;

  // Reads still travelling through the memory pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_tag[i]);
    end
  end

  // Issuing is gated on reserved FIFO space so every returning word has a slot.
  assign w_issue = (r_state == S_FETCH) && ((r_count + w_inflight) < CNT_W'(FIFO_DEPTH));
  assign w_ret   = r_tag[READ_LATENCY-1];

  assign w_rec_x = zbt_read_data[29:20];
  assign w_rec_y = zbt_read_data[19:10];
  // 11-bit sum: x (max 1023) plus a small offset never wraps.
  assign w_xs    = {1'b0, w_rec_x} + 11'(r_offset);

`ifdef POINT_RENDERER_DEPTH_INVERT_EN
  assign w_pixel = ~zbt_read_data[9:2];
`else
  assign w_pixel = zbt_read_data[9:2];
`endif

  assign w_unused_bits = ^{zbt_read_data[35:30], zbt_read_data[1:0]};

  assign w_clip  = (32'(w_xs) >= SCREEN_W) || (32'(w_rec_y) >= SCREEN_H);
  assign w_push  = w_ret && !w_clip;
  assign w_pop   = (r_count != '0) && out_ready;
  assign w_entry = {w_xs, w_rec_y, w_pixel};
  assign w_head  = r_fifo[r_rd_ptr];

  // Tag shift register: one bit per issued read, marks the cycle its data is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag <= (r_tag << 1) | READ_LATENCY'(w_issue);
    end
  end

  // Frame control: idle/fetch/drain sequencing, address generation, clip counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_offset     <= '0;
      r_index      <= '0;
      r_addr       <= BASE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_clip_count <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_ret && w_clip && (r_clip_count != '1)) begin
        r_clip_count <= r_clip_count + ADDR_WIDTH'(1);
      end
      case (r_state)
        S_IDLE: begin
          // busy stays high through the frame_done cycle, so a start then is ignored.
          r_busy <= 1'b0;
          if (frame_start && !r_busy) begin
            r_state      <= S_FETCH;
            r_offset     <= camera_offset;
            r_index      <= '0;
            r_clip_count <= '0;
            r_busy       <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_addr  <= BASE + r_index[ADDR_WIDTH-1:0];
            r_index <= r_index + IDX_W'(1);
            if (r_index == LAST_IDX) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((w_inflight == '0) && (r_count == '0)) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output buffer: push returned on-screen points, pop on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_entry;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign zbt_read_addr = r_addr;
  assign out_valid     = (r_count != '0);
  assign x             = w_head.x;
  assign y             = w_head.y;
  assign pixel         = w_head.pixel;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign clip_count    = r_clip_count;

endmodule

// File: tb/tb_point_renderer.sv
// Directed bench for point_renderer: 4-point frames, clipping, backpressure, restart and reset rules.
module tb_point_renderer;

  localparam int AW   = 19;
  localparam int BASE = 8;
  localparam int NP   = 4;
  localparam int RL   = 2;
  localparam int FD   = 4;
  localparam int OW   = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [OW-1:0] camera_offset;
  logic [35:0]   zbt_read_data;
  logic [AW-1:0] zbt_read_addr;
  logic          out_ready;
  logic          out_valid;
  logic [10:0]   x;
  logic [9:0]    y;
  logic [7:0]    pixel;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] clip_count;

  point_renderer #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .NUM_POINTS(NP), .READ_LATENCY(RL),
    .FIFO_DEPTH(FD), .OFFSET_WIDTH(OW), .SCREEN_W(1024), .SCREEN_H(768)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .camera_offset(camera_offset),
    .zbt_read_data(zbt_read_data), .zbt_read_addr(zbt_read_addr), .out_ready(out_ready),
    .out_valid(out_valid), .x(x), .y(y), .pixel(pixel), .busy(busy),
    .frame_done(frame_done), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  // Memory model: data for an address is sampled RL edges after the address is driven.
  logic [35:0]   mem [0:15];
  logic [AW-1:0] addr_d = '0;
  always @(posedge clk) addr_d <= zbt_read_addr;
  assign zbt_read_data = mem[addr_d[3:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_x[$];
  int q_y[$];
  int q_p[$];
  int fd_cnt = 0;
  int fd_cyc = 0;
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
      q_x.push_back(int'(x));
      q_y.push_back(int'(y));
      q_p.push_back(int'(pixel));
    end
    if (frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  bit ovf = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if ((dut.r_count + dut.w_inflight) > FD) ovf = 1'b1;
      if (dut.w_push && !dut.w_pop && dut.r_count == FD) ovf = 1'b1;
    end
  end

  bit          stall_mon = 1'b0;
  bit          unstable  = 1'b0;
  logic [28:0] held      = '0;
  always @(negedge clk) begin
    if (stall_mon) begin
      if (out_valid !== 1'b1 || {x, y, pixel} !== held) unstable = 1'b1;
    end
  end

  function automatic logic [35:0] rec(input int xv, input int yv, input int zv);
    return {6'b0, 10'(xv), 10'(yv), 10'(zv)};
  endfunction

  function automatic int epix(input int z);
`ifdef POINT_RENDERER_DEPTH_INVERT_EN
    return 255 - ((z >> 2) & 255);
`else
    return (z >> 2) & 255;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse frame_start for one edge; returns cyc value just after the accepting edge.
  task automatic start_frame(output int s0);
    frame_start = 1'b1;
    step(1);
    s0 = cyc;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, input int maxc);
    int k;
    k = 0;
    while (fd_cnt == base_cnt && k < maxc) begin
      step(1);
      k++;
    end
    check("done_seen", 32'(fd_cnt > base_cnt), 32'd1);
  endtask

  task automatic clear_q();
    q_x.delete();
    q_y.delete();
    q_p.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int fdb;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1'b1;
    frame_start = 1'b0;
    out_ready = 1'b1;
    camera_offset = '0;
    step(3);

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    check("rst_addr", 32'(zbt_read_addr), 32'(BASE));
    reset = 1'b0;
    step(1);

    // Basic frame: x=10i, y=i, z=4i, offset 5
    for (int i = 0; i < NP; i++) mem[BASE+i] = rec(10*i, i, 4*i);
    camera_offset = 6'd5;
    clear_q();
    fdb = fd_cnt;
    start_frame(s0);
    check("basic_busy", 32'(busy), 32'd1);
    wait_done(fdb, 40);
    check("basic_latency", 32'(fd_cyc - s0), 32'(NP + RL + 2));
    check("basic_done_once", 32'(fd_cnt - fdb), 32'd1);
    check("basic_count", 32'(q_x.size()), 32'(NP));
    for (int i = 0; i < NP && i < q_x.size(); i++) begin
      check("basic_x", 32'(q_x[i]), 32'(10*i + 5));
      check("basic_y", 32'(q_y[i]), 32'(i));
      check("basic_pixel", 32'(q_p[i]), 32'(epix(4*i)));
    end
    check("basic_clip", 32'(clip_count), 32'd0);
    check("basic_last_addr", 32'(zbt_read_addr), 32'(BASE + NP - 1));
    step(2);
    check("basic_busy_after", 32'(busy), 32'd0);

    // Clipping: x overflow, y at bound, x exactly at last column, plus one plain point
    mem[BASE+0] = rec(1020, 1, 8);
    mem[BASE+1] = rec(100, 768, 40);
    mem[BASE+2] = rec(1013, 767, 1023);
    mem[BASE+3] = rec(0, 0, 0);
    camera_offset = 6'd10;
    clear_q();
    fdb = fd_cnt;
    start_frame(s0);
    wait_done(fdb, 40);
    check("clip_count", 32'(clip_count), 32'd2);
    check("clip_outputs", 32'(q_x.size()), 32'd2);
    if (q_x.size() == 2) begin
      check("clip_edge_x", 32'(q_x[0]), 32'd1023);
      check("clip_edge_y", 32'(q_y[0]), 32'd767);
      check("clip_edge_pix", 32'(q_p[0]), 32'(epix(1023)));
      check("clip_plain_x", 32'(q_x[1]), 32'd10);
      check("clip_plain_pix", 32'(q_p[1]), 32'(epix(0)));
    end
    step(2);

    // Backpressure with a stray frame_start and an offset change mid-frame
    for (int i = 0; i < NP; i++) mem[BASE+i] = rec(100 + i, 10 + i, 8*i + 4);
    camera_offset = 6'd3;
    clear_q();
    ovf = 1'b0;
    fdb = fd_cnt;
    start_frame(s0);
    step(1);
    out_ready = 1'b0;
    step(3);
    held = {11'd103, 10'd10, 8'(epix(4))};
    unstable = 1'b0;
    stall_mon = 1'b1;
    frame_start = 1'b1;
    camera_offset = 6'd40;
    step(1);
    frame_start = 1'b0;
    step(19);
    stall_mon = 1'b0;
    check("bp_stable", 32'(unstable), 32'd0);
    check("bp_head_x", 32'(x), 32'd103);
    check("bp_none_taken", 32'(q_x.size()), 32'd0);
    out_ready = 1'b1;
    wait_done(fdb, 40);
    step(15);
    check("bp_no_overflow", 32'(ovf), 32'd0);
    check("bp_done_once", 32'(fd_cnt - fdb), 32'd1);
    check("bp_busy_idle", 32'(busy), 32'd0);
    check("bp_clip_reset", 32'(clip_count), 32'd0);
    check("bp_count", 32'(q_x.size()), 32'(NP));
    for (int i = 0; i < NP && i < q_x.size(); i++) begin
      check("bp_x", 32'(q_x[i]), 32'(103 + i));
      check("bp_y", 32'(q_y[i]), 32'(10 + i));
      check("bp_pixel", 32'(q_p[i]), 32'(epix(8*i + 4)));
    end

    // Restart after frame_done begins again at BASE_ADDR
    camera_offset = 6'd0;
    clear_q();
    fdb = fd_cnt;
    start_frame(s0);
    step(1);
    check("restart_addr", 32'(zbt_read_addr), 32'(BASE));
    wait_done(fdb, 40);
    check("restart_count", 32'(q_x.size()), 32'(NP));
    if (q_x.size() == NP) begin
      check("restart_first_x", 32'(q_x[0]), 32'd100);
      check("restart_last_x", 32'(q_x[NP-1]), 32'(100 + NP - 1));
    end
    step(2);

    // Reset with two reads in flight
    for (int i = 0; i < NP; i++) mem[BASE+i] = rec(10*i, i, 4*i);
    camera_offset = 6'd7;
    clear_q();
    fdb = fd_cnt;
    start_frame(s0);
    step(2);
    reset = 1'b1;
    step(1);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", 32'(zbt_read_addr), 32'(BASE));
    check("mrst_x", 32'(x), 32'd0);
    check("mrst_done", 32'(frame_done), 32'd0);
    check("mrst_clip", 32'(clip_count), 32'd0);
    reset = 1'b0;
    step(12);
    check("mrst_no_push", 32'(q_x.size()), 32'd0);
    check("mrst_valid_later", 32'(out_valid), 32'd0);
    check("mrst_no_done", 32'(fd_cnt - fdb), 32'd0);

    // Full frame after reset recovery, offset 0
    camera_offset = 6'd0;
    clear_q();
    fdb = fd_cnt;
    start_frame(s0);
    wait_done(fdb, 40);
    check("rec_latency", 32'(fd_cyc - s0), 32'(NP + RL + 2));
    check("rec_count", 32'(q_x.size()), 32'(NP));
    for (int i = 0; i < NP && i < q_x.size(); i++) begin
      check("rec_x", 32'(q_x[i]), 32'(10*i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/point_renderer.md
Name: point_renderer

Overview:
- Streams a frame's worth of packed point records out of ZBT memory.
- Applies a per-frame horizontal camera offset, clips points that fall off-screen, and derives an 8-bit depth intensity.
- Delivers one point per cycle to the pixel writer over a valid/ready handshake.
- Parametrised successor to the free-running single-word point fetch: adds a bounded point count, a memory read-latency pipeline, backpressure buffering, clipping and frame start/done control.

Parameters:
- ADDR_WIDTH, 19, ZBT word address width.
- BASE_ADDR, 0, address of point 0.
- NUM_POINTS, 1024, points per frame (1..2^ADDR_WIDTH-BASE_ADDR).
- READ_LATENCY, 2, cycles from zbt_read_addr to valid zbt_read_data (>=1).
- FIFO_DEPTH, 4, output buffer entries (>=READ_LATENCY+1, power of 2).
- OFFSET_WIDTH, 6, camera_offset width.
- SCREEN_W, 1024, x clip bound (exclusive).
- SCREEN_H, 768, y clip bound (exclusive).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; begins a frame when idle
- camera_offset  in  OFFSET_WIDTH  unsigned x shift, sampled at accepted frame_start
- zbt_read_data  in  36  record: [29:20]=x, [19:10]=y, [9:0]=z, others ignored
- zbt_read_addr  out  ADDR_WIDTH  read address
- out_ready  in  1  downstream accepts point
- out_valid  out  1  point available
- x  out  11  offset x (always < SCREEN_W)
- y  out  10  y
- pixel  out  8  depth intensity
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last point handed off
- clip_count  out  ADDR_WIDTH  points discarded this frame

Behaviour:
- Reset values: zbt_read_addr=BASE_ADDR, out_valid=0, x=0, y=0, pixel=0, busy=0, frame_done=0, clip_count=0.
- Reset also does the following:
  - FIFO emptied.
  - In-flight read tags cleared; data returning after reset is discarded.
  - State goes to IDLE.
  - Reset mid-frame aborts the frame with no frame_done.
- States:
  - IDLE: frame_start -> FETCH. Next cycle: latch offset, index=0, clip_count=0, busy=1.
  - FETCH: issue reads; after the read for index NUM_POINTS-1 has issued -> DRAIN.
  - DRAIN: wait until in-flight=0 and FIFO empty -> IDLE. frame_done=1 for exactly that transition cycle, busy=0 from the next cycle.
- frame_start while busy is ignored. The latched offset does not change mid-frame.
- Read issue rule, in FETCH: issue when (fifo_count + inflight) < FIFO_DEPTH.
  - On issue: zbt_read_addr=BASE_ADDR+index, index increments.
  - Issuing stalls otherwise, so the FIFO never overflows.
- Read tracking:
  - A READ_LATENCY-deep tag shift register marks returning data.
  - inflight = count of set tags.
  - When not issuing, zbt_read_addr holds its last value.
- Return path, on a returned word:
  - xs = data[29:20] + offset, 11-bit, no wrap.
  - If xs >= SCREEN_W or data[19:10] >= SCREEN_H: drop the point, clip_count+1, saturating at all-ones.
  - Else push {xs, y, pixel} into the FIFO.
- pixel = z[9:2] by default.
- Output:
  - out_valid = FIFO not empty.
  - x, y and pixel show the head entry.
  - Pop when out_valid && out_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Simultaneous push and pop on the same cycle is legal; count is unchanged.
- Push into a full FIFO cannot occur by construction; the bench asserts this.
- Steady state with out_ready=1: one point per cycle after an initial READ_LATENCY+1 cycles.
- Total frame_start-to-frame_done time with out_ready=1 and no clipping: NUM_POINTS+READ_LATENCY+2 cycles.
- NUM_POINTS=1: FETCH lasts one issue, then DRAIN.
- The last address issued is BASE_ADDR+NUM_POINTS-1; the index never wraps into the next region.

Optional Feature:
- Macro: POINT_RENDERER_DEPTH_INVERT_EN.
- Defined: pixel = ~z[9:2], so near points (small z) render bright.
- Undefined: pixel = z[9:2].
- Clipping, timing and all other behaviour are identical in both builds.

Test Plan:
- Basic frame:
  - Setup: NUM_POINTS=4, READ_LATENCY=2, out_ready=1. Memory words 0..3 = x=10*i, y=i, z=4*i. offset=5, pulse frame_start.
  - Required: 4 outputs x=5,15,25,35; y=0..3; pixel=0,1,2,3. frame_done 1 cycle at cycle 8. clip_count=0.
- Clipping:
  - Setup: record x=1020, offset=10; second record y=768.
  - Required: both dropped, clip_count=2, no out_valid for them. x=1013 with offset 10 passes as 1023.
- Backpressure:
  - Setup: out_ready=0 for 20 cycles mid-frame.
  - Required: out_valid held, head data stable. inflight+count never exceeds 4. No point lost or duplicated; all NUM_POINTS delivered in address order.
- Restart rules:
  - Setup: frame_start while busy; offset changed mid-frame.
  - Required: ignored; all points of the frame use the original offset. New frame_start after frame_done restarts at BASE_ADDR.
- Reset mid-frame:
  - Setup: assert reset with 2 reads in flight.
  - Required: all outputs at reset values next cycle. Returned stale data not pushed. No frame_done.
- Depth invert:
  - Setup: build with POINT_RENDERER_DEPTH_INVERT_EN, z=0 and z=1023.
  - Required: pixel=255 and 0 respectively.
